// File: rtl/btb_predictor_pkg.sv
// Shared types and defaults for the BTB predictor slice: index/tag widths,
// 2-bit counter type, FSM state enum and the IF->EX prediction metadata record.
package bp_pkg;

    localparam int IDX_W_DEF = 10;
    localparam int TAG_W_DEF = 20;

    typedef logic [1:0] cnt2_t;

    localparam cnt2_t CNT_INIT_DEF = 2'b01;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic [31:0] target;
    } pred_meta_t;

    // Two-bit saturating step: up counts towards 2'b11, down towards 2'b00.
    function automatic cnt2_t sat_update(input cnt2_t c, input logic up);
        cnt2_t r;
        r = c;
        if (up) begin
            if (c != 2'b11) r = c + 2'b01;
        end else begin
            if (c != 2'b00) r = c - 2'b01;
        end
        return r;
    endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Port bundle between the predictor (master) and the external BTB storage (slave):
// one asynchronous read port indexed from the fetch PC and one write port.
interface btb_predictor_if #(
    parameter int IDX_W = 10,
    parameter int TAG_W = 20
);
    // No back-pressure: the read returns data in the same cycle, and
    // btb_we_o is a single-cycle strobe that the BTB must accept on that edge.
    logic [IDX_W-1:0] btb_addr_rd_o;
    logic [TAG_W-1:0] btb_tag_i;
    logic [31:0]      btb_pc_i;
    logic             btb_used_i;
    logic             btb_we_o;
    logic [IDX_W-1:0] btb_addr_wr_o;
    logic [TAG_W-1:0] btb_tag_wr_o;
    logic [31:0]      btb_pc_wr_o;

    modport master (
        output btb_addr_rd_o, btb_we_o, btb_addr_wr_o, btb_tag_wr_o, btb_pc_wr_o,
        input  btb_tag_i, btb_pc_i, btb_used_i
    );

    modport slave (
        input  btb_addr_rd_o, btb_we_o, btb_addr_wr_o, btb_tag_wr_o, btb_pc_wr_o,
        output btb_tag_i, btb_pc_i, btb_used_i
    );

endinterface

// File: rtl/btb_predictor_bht.sv
// Branch history table: 2**IDX_W two-bit counters, combinational read, one write
// port shared by the init sweep (constant fill) and saturating training.
module bht
    import bp_pkg::*;
#(
    parameter int    IDX_W    = IDX_W_DEF,
    parameter cnt2_t CNT_INIT = CNT_INIT_DEF
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] i_rd_idx,
    output cnt2_t            o_rd_cnt,
    input  logic             i_init_we,
    input  logic [IDX_W-1:0] i_init_idx,
    input  logic             i_train_we,
    input  logic [IDX_W-1:0] i_train_idx,
    input  logic             i_train_up
);

    localparam int DEPTH = 1 << IDX_W;

    // Deliberately unreset: the init sweep defines every entry before use.
    cnt2_t r_table [DEPTH];

    assign o_rd_cnt = r_table[i_rd_idx];

    always_ff @(posedge clk) begin
        if (i_init_we) begin
            r_table[i_init_idx] <= CNT_INIT;
        end else if (i_train_we) begin
            r_table[i_train_idx] <= sat_update(r_table[i_train_idx], i_train_up);
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// BTB fetch lookup + BHT prediction, IF->ID->EX metadata pipe and EX-side training.
// Optional statistics counters are compiled in with `define BTB_PRED_STATS_EN.
module btb_predictor
    import bp_pkg::*;
#(
    parameter int    IDX_W    = IDX_W_DEF,
    parameter int    TAG_W    = TAG_W_DEF,   // must equal 30 - IDX_W
    parameter cnt2_t CNT_INIT = CNT_INIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            if_pc_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    btb_predictor_if.master        btb,
    output logic                   pred_taken_o,
    output logic [31:0]            pred_pc_o,
    input  logic                   ex_valid_i,
    input  logic                   ex_is_branch_i,
    input  logic                   ex_taken_i,
    input  logic [31:0]            ex_pc_i,
    input  logic [31:0]            ex_target_i,
    output logic                   mispredict_o,
    output logic [31:0]            redirect_pc_o,
    output logic                   ready_o,
    output state_e                 dbg_state_o
`ifdef BTB_PRED_STATS_EN
    ,
    output logic [31:0]            stat_branches_o,
    output logic [31:0]            stat_mispred_o
`endif
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDX_W-1:0] r_init_idx;
    logic             w_ready;
    logic             w_init_we;

    pred_meta_t       w_meta_if;
    pred_meta_t       r_meta_id;
    pred_meta_t       r_meta_ex;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    cnt2_t            w_bht_cnt;
    logic             w_hit;
    logic             w_act;
    logic             w_mispredict;
    logic             w_upd;
    logic             w_train;
    logic             w_clear;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= INIT;
        else        r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    if (r_init_idx == '1) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_ready   = 1'b0;
        w_init_we = 1'b0;
        case (r_state)
            INIT:    w_init_we = 1'b1;
            RUN:     w_ready   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_init_idx <= '0;
        else if (w_init_we) r_init_idx <= r_init_idx + IDX_W'(1);
    end

    assign ready_o     = w_ready;
    assign dbg_state_o = r_state;

    // Fetch-side lookup
    assign w_if_idx          = if_pc_i[IDX_W+1:2];
    assign w_if_tag          = if_pc_i[31:IDX_W+2];
    assign btb.btb_addr_rd_o = w_if_idx;
    assign w_hit             = btb.btb_used_i && (btb.btb_tag_i == w_if_tag);
    assign pred_taken_o      = w_ready && w_hit && w_bht_cnt[1];
    assign pred_pc_o         = pred_taken_o ? btb.btb_pc_i : if_pc_i + 32'd4;

    assign w_meta_if = '{valid: w_ready, taken: pred_taken_o, target: btb.btb_pc_i};

    // EX-side resolution
    assign w_ex_idx      = ex_pc_i[IDX_W+1:2];
    assign w_ex_tag      = ex_pc_i[31:IDX_W+2];
    assign w_act         = ex_valid_i && ex_is_branch_i && ex_taken_i;
    assign w_mispredict  = w_ready && ex_valid_i && r_meta_ex.valid &&
                           ((r_meta_ex.taken != w_act) ||
                            (w_act && (r_meta_ex.target != ex_target_i)));
    assign mispredict_o  = w_mispredict;
    assign redirect_pc_o = w_act ? ex_target_i : ex_pc_i + 32'd4;

    // Non-branches only train when they were predicted taken, so aliases unlearn.
    assign w_upd   = w_ready && ex_valid_i && !stall_i;
    assign w_train = w_upd && (ex_is_branch_i || r_meta_ex.taken);

    assign btb.btb_we_o      = w_upd && w_act;
    assign btb.btb_addr_wr_o = w_ex_idx;
    assign btb.btb_tag_wr_o  = w_ex_tag;
    assign btb.btb_pc_wr_o   = ex_target_i;

    // A mispredict under stall keeps EX meta so the resolution repeats on release.
    assign w_clear = flush_i || (w_mispredict && !stall_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta_id <= '0;
            r_meta_ex <= '0;
        end else if (w_clear) begin
            r_meta_id <= '0;
            r_meta_ex <= '0;
        end else if (!stall_i) begin
            r_meta_id <= w_meta_if;
            r_meta_ex <= r_meta_id;
        end
    end

    bht #(
        .IDX_W    (IDX_W),
        .CNT_INIT (CNT_INIT)
    ) u_bht (
        .clk         (clk),
        .i_rd_idx    (w_if_idx),
        .o_rd_cnt    (w_bht_cnt),
        .i_init_we   (w_init_we),
        .i_init_idx  (r_init_idx),
        .i_train_we  (w_train),
        .i_train_idx (w_ex_idx),
        .i_train_up  (w_act)
    );

`ifdef BTB_PRED_STATS_EN
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_br  <= '0;
            r_stat_mis <= '0;
        end else begin
            if (w_train && ex_is_branch_i && (r_stat_br != '1))
                r_stat_br <= r_stat_br + 32'd1;
            if (w_mispredict && (r_stat_mis != '1))
                r_stat_mis <= r_stat_mis + 32'd1;
        end
    end

    assign stat_branches_o = r_stat_br;
    assign stat_mispred_o  = r_stat_mis;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: models the external BTB storage and
// scoreboards every BTB write against the resolutions driven into EX.
`timescale 1ns/1ps
module tb_btb_predictor;
    import bp_pkg::*;

    localparam int IDX_W = 10;
    localparam int TAG_W = 20;
    localparam int DEPTH = 1 << IDX_W;
    localparam int SB_W  = IDX_W + TAG_W + 32;

    localparam logic [31:0] PC_BR    = 32'h0000_1040;
    localparam logic [31:0] PC_TGT   = 32'h0000_2000;
    localparam logic [31:0] PC_ALIAS = 32'h0000_5040;
    localparam logic [31:0] PC_JUNK  = 32'h0000_3010;
    localparam logic [31:0] PC_NEUT  = 32'h0000_8000;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] if_pc_i;
    logic        stall_i, flush_i;
    logic        pred_taken_o;
    logic [31:0] pred_pc_o;
    logic        ex_valid_i, ex_is_branch_i, ex_taken_i;
    logic [31:0] ex_pc_i, ex_target_i;
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic        ready_o;
    state_e      dbg_state_o;
`ifdef BTB_PRED_STATS_EN
    logic [31:0] stat_branches_o, stat_mispred_o;
`endif

    btb_predictor_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bif ();

    btb_predictor #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc_i        (if_pc_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .btb            (bif.master),
        .pred_taken_o   (pred_taken_o),
        .pred_pc_o      (pred_pc_o),
        .ex_valid_i     (ex_valid_i),
        .ex_is_branch_i (ex_is_branch_i),
        .ex_taken_i     (ex_taken_i),
        .ex_pc_i        (ex_pc_i),
        .ex_target_i    (ex_target_i),
        .mispredict_o   (mispredict_o),
        .redirect_pc_o  (redirect_pc_o),
        .ready_o        (ready_o),
        .dbg_state_o    (dbg_state_o)
`ifdef BTB_PRED_STATS_EN
        ,
        .stat_branches_o(stat_branches_o),
        .stat_mispred_o (stat_mispred_o)
`endif
    );

    // BTB storage model (not reset, like the real array)
    logic [TAG_W-1:0] m_tag  [DEPTH];
    logic [31:0]      m_pc   [DEPTH];
    logic             m_used [DEPTH];

    assign bif.btb_tag_i  = m_tag[bif.btb_addr_rd_o];
    assign bif.btb_pc_i   = m_pc[bif.btb_addr_rd_o];
    assign bif.btb_used_i = m_used[bif.btb_addr_rd_o];

    always @(posedge clk) begin
        if (bif.btb_we_o) begin
            m_tag[bif.btb_addr_wr_o]  <= bif.btb_tag_wr_o;
            m_pc[bif.btb_addr_wr_o]   <= bif.btb_pc_wr_o;
            m_used[bif.btb_addr_wr_o] <= 1'b1;
        end
    end

    // scoreboard
    logic [SB_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        logic [SB_W-1:0] exp_w;
        logic [SB_W-1:0] got_w;
        if (bif.btb_we_o === 1'b1) begin
            got_w = {bif.btb_addr_wr_o, bif.btb_tag_wr_o, bif.btb_pc_wr_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL btb_write_unexpected: got %h, expected no write", got_w);
            end else begin
                exp_w = exp_q.pop_front();
                if (got_w !== exp_w) begin
                    errors++;
                    $display("FAIL btb_write: got %h, expected %h", got_w, exp_w);
                end
            end
        end
    end

    // driver: apply one cycle of inputs after the edge, return at the sampling edge
    task automatic drive(input logic [31:0] ipc, input logic exv, input logic br,
                         input logic tk, input logic [31:0] epc,
                         input logic [31:0] etgt, input logic stl);
        @(posedge clk);
        #1;
        if_pc_i        = ipc;
        ex_valid_i     = exv;
        ex_is_branch_i = br;
        ex_taken_i     = tk;
        ex_pc_i        = epc;
        ex_target_i    = etgt;
        stall_i        = stl;
        if (exv && br && tk && !stl)
            exp_q.push_back({epc[IDX_W+1:2], epc[31:IDX_W+2], etgt});
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] ipc);
        drive(ipc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic wait_ready(output int n, output logic pt_seen);
        n = 0;
        pt_seen = 1'b0;
        while (n < 1100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (pred_taken_o !== 1'b0) pt_seen = 1'b1;
            if (ready_o === 1'b1) break;
        end
    endtask

    // fetch pc, let it travel to EX, resolve it there
    task automatic issue_branch(input string name, input logic [31:0] pc, input logic tk,
                                input logic [31:0] tgt, input logic exp_pt,
                                input logic [31:0] exp_ppc, input logic exp_mis);
        logic [31:0] exp_redir;
        exp_redir = tk ? tgt : pc + 32'd4;
        idle(pc);
        checks++;
        if (pred_taken_o !== exp_pt || pred_pc_o !== exp_ppc) begin
            errors++;
            $display("FAIL %s_fetch: taken=%b pc=%h, expected %b %h",
                     name, pred_taken_o, pred_pc_o, exp_pt, exp_ppc);
        end
        idle(PC_NEUT);
        drive(PC_NEUT, 1'b1, 1'b1, tk, pc, tgt, 1'b0);
        checks++;
        if (mispredict_o !== exp_mis || redirect_pc_o !== exp_redir) begin
            errors++;
            $display("FAIL %s_resolve: mispredict=%b redirect=%h, expected %b %h",
                     name, mispredict_o, redirect_pc_o, exp_mis, exp_redir);
        end
        idle(PC_NEUT);
    endtask

    task automatic test_reset();
        int n;
        logic pt_seen;
        if_pc_i = PC_JUNK;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || dbg_state_o !== INIT) begin
            errors++;
            $display("FAIL reset_state: ready=%b state=%0d, expected 0 INIT", ready_o, dbg_state_o);
        end
        checks++;
        if (pred_taken_o !== 1'b0 || mispredict_o !== 1'b0 || bif.btb_we_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: pt=%b mis=%b we=%b, expected 0 0 0",
                     pred_taken_o, mispredict_o, bif.btb_we_o);
        end
        rst_n = 1'b1;
        wait_ready(n, pt_seen);
        checks++;
        if (n != 1024) begin
            errors++;
            $display("FAIL init_length: ready after %0d cycles, expected 1024", n);
        end
        checks++;
        if (pt_seen !== 1'b0) begin
            errors++;
            $display("FAIL init_no_predict: pred_taken seen=%b, expected 0", pt_seen);
        end
        // unreset junk entry that hits must still predict not-taken
        checks++;
        if (pred_taken_o !== 1'b0 || pred_pc_o !== PC_JUNK + 32'd4 || dbg_state_o !== RUN) begin
            errors++;
            $display("FAIL junk_entry: pt=%b pc=%h state=%0d, expected 0 %h RUN",
                     pred_taken_o, pred_pc_o, dbg_state_o, PC_JUNK + 32'd4);
        end
    endtask

    task automatic test_train();
        issue_branch("train1", PC_BR, 1'b1, PC_TGT, 1'b0, PC_BR + 32'd4, 1'b1);
        issue_branch("train2", PC_BR, 1'b1, PC_TGT, 1'b1, PC_TGT, 1'b0);
        idle(PC_BR);
        checks++;
        if (pred_taken_o !== 1'b1 || pred_pc_o !== PC_TGT) begin
            errors++;
            $display("FAIL predict_trained: pt=%b pc=%h, expected 1 %h", pred_taken_o, pred_pc_o, PC_TGT);
        end
    endtask

    task automatic test_mispredict();
        idle(PC_BR);
        idle(PC_BR);
        drive(PC_BR, 1'b1, 1'b1, 1'b0, PC_BR, 32'h0, 1'b0);
        checks++;
        if (mispredict_o !== 1'b1 || redirect_pc_o !== PC_BR + 32'd4) begin
            errors++;
            $display("FAIL mispredict: mis=%b redirect=%h, expected 1 %h",
                     mispredict_o, redirect_pc_o, PC_BR + 32'd4);
        end
        // predicted-taken entries behind it must have been dropped
        drive(PC_NEUT, 1'b1, 1'b0, 1'b0, PC_BR, 32'h0, 1'b0);
        checks++;
        if (mispredict_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_id: mis=%b, expected 0", mispredict_o);
        end
        drive(PC_NEUT, 1'b1, 1'b0, 1'b0, PC_BR, 32'h0, 1'b0);
        checks++;
        if (mispredict_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_if: mis=%b, expected 0", mispredict_o);
        end
        idle(PC_BR);
        checks++;
        if (pred_taken_o !== 1'b1 || pred_pc_o !== PC_TGT) begin
            errors++;
            $display("FAIL bht_11_to_10: pt=%b pc=%h, expected 1 %h", pred_taken_o, pred_pc_o, PC_TGT);
        end
    endtask

    task automatic test_alias();
        idle(PC_ALIAS);
        checks++;
        if (pred_taken_o !== 1'b0 || pred_pc_o !== PC_ALIAS + 32'd4) begin
            errors++;
            $display("FAIL alias: pt=%b pc=%h, expected 0 %h",
                     pred_taken_o, pred_pc_o, PC_ALIAS + 32'd4);
        end
    endtask

    task automatic test_stall();
        idle(PC_BR);
        idle(PC_NEUT);
        for (int i = 0; i < 3; i++) begin
            drive(PC_NEUT, 1'b1, 1'b1, 1'b0, PC_BR, 32'h0, 1'b1);
            checks++;
            if (mispredict_o !== 1'b1 || bif.btb_we_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d: mis=%b we=%b, expected 1 0",
                         i, mispredict_o, bif.btb_we_o);
            end
        end
        drive(PC_NEUT, 1'b1, 1'b1, 1'b0, PC_BR, 32'h0, 1'b0);
        checks++;
        if (mispredict_o !== 1'b1 || redirect_pc_o !== PC_BR + 32'd4) begin
            errors++;
            $display("FAIL stall_release: mis=%b redirect=%h, expected 1 %h",
                     mispredict_o, redirect_pc_o, PC_BR + 32'd4);
        end
        // one decrement (10->01) then one increment must predict taken again
        issue_branch("stall_retrain", PC_BR, 1'b1, PC_TGT, 1'b0, PC_BR + 32'd4, 1'b1);
        idle(PC_BR);
        checks++;
        if (pred_taken_o !== 1'b1 || pred_pc_o !== PC_TGT) begin
            errors++;
            $display("FAIL stall_trained_once: pt=%b pc=%h, expected 1 %h",
                     pred_taken_o, pred_pc_o, PC_TGT);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        logic pt_seen;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0 || pred_taken_o !== 1'b0 || dbg_state_o !== INIT) begin
            errors++;
            $display("FAIL midreset_async: ready=%b pt=%b state=%0d, expected 0 0 INIT",
                     ready_o, pred_taken_o, dbg_state_o);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n, pt_seen);
        checks++;
        if (n != 1024 || pt_seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_sweep: cycles=%0d pt_seen=%b, expected 1024 0", n, pt_seen);
        end
        checks++;
        if (pred_taken_o !== 1'b0 || pred_pc_o !== PC_BR + 32'd4) begin
            errors++;
            $display("FAIL midreset_forgot: pt=%b pc=%h, expected 0 %h",
                     pred_taken_o, pred_pc_o, PC_BR + 32'd4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_tag[i]  = TAG_W'($urandom_range(0, 15));
            m_pc[i]   = $urandom;
            m_used[i] = 1'b0;
        end
        m_used[PC_JUNK[IDX_W+1:2]] = 1'b1;
        m_tag[PC_JUNK[IDX_W+1:2]]  = PC_JUNK[31:IDX_W+2];
        m_pc[PC_JUNK[IDX_W+1:2]]   = 32'h7777_0000;

        if_pc_i        = 32'h0;
        stall_i        = 1'b0;
        flush_i        = 1'b0;
        ex_valid_i     = 1'b0;
        ex_is_branch_i = 1'b0;
        ex_taken_i     = 1'b0;
        ex_pc_i        = 32'h0;
        ex_target_i    = 32'h0;

        test_reset();
        test_train();
        test_mispredict();
        test_alias();
        test_stall();
        test_mid_reset();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d writes outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Fetch-side lookup and execute-side update controller for the 1024-entry branch target buffer.
- In IF it drives the BTB read index, checks the returned tag and valid bit, and combines the result with a 2-bit saturating-counter history table (BHT) to produce a taken/target prediction.
- It carries the prediction metadata through ID to EX, compares it with the resolved branch, issues mispredict/redirect, and drives the BTB write port and BHT training.

Parameters:
- IDX_W, 10, index bits taken from pc[IDX_W+1:2]; table depth is 2**IDX_W.
- TAG_W, 20, tag bits = pc[31:IDX_W+2]; TAG_W must equal 30-IDX_W.
- CNT_INIT, 2'b01, BHT value written to every entry by the init sweep (weakly not-taken).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- if_pc_i  in  32  fetch PC.
- stall_i  in  1  freeze metadata pipe and suppress training.
- flush_i  in  1  clear IF/ID metadata stages.
- btb_addr_rd_o  out  IDX_W  BTB read index = if_pc_i[IDX_W+1:2].
- btb_tag_i  in  TAG_W  tag read from the BTB.
- btb_pc_i  in  32  target read from the BTB.
- btb_used_i  in  1  entry-valid bit read from the BTB.
- pred_taken_o  out  1  IF prediction (combinational).
- pred_pc_o  out  32  next fetch PC: target if predicted taken, else if_pc_i+4.
- ex_valid_i  in  1  EX holds a real instruction.
- ex_is_branch_i  in  1  EX instruction is a branch or jump.
- ex_taken_i  in  1  resolved direction.
- ex_pc_i  in  32  EX instruction PC.
- ex_target_i  in  32  resolved target.
- btb_we_o  out  1  BTB write enable.
- btb_addr_wr_o  out  IDX_W  BTB write index.
- btb_tag_wr_o  out  TAG_W  BTB write tag.
- btb_pc_wr_o  out  32  BTB write target.
- mispredict_o  out  1  EX prediction was wrong (combinational).
- redirect_pc_o  out  32  correct next PC.
- ready_o  out  1  init sweep complete.

Behaviour:
- FSM has two states, INIT and RUN.
  - Reset, including assertion mid-operation, forces INIT with sweep index 0.
  - INIT writes CNT_INIT to BHT[idx] once per cycle, 0 to 2**IDX_W-1, then moves to RUN. The sweep takes 1024 cycles at the defaults.
  - The sweep makes unreset BTB contents harmless: an entry predicts taken only after the same index has been trained.
- Reset values and INIT outputs:
  - ready_o=0, pred_taken_o=0, mispredict_o=0, btb_we_o=0.
  - Metadata valid bits are 0; training inputs are ignored.
- Hit and prediction:
  - hit = btb_used_i && btb_tag_i==if_pc_i[31:IDX_W+2].
  - pred_taken_o = ready_o && hit && BHT[idx][1].
- BHT read is combinational. Writes take effect at the clock edge, so a same-cycle read of the index being trained sees the old value. The BTB behaves the same way.
- Metadata pipe {valid, taken, target} runs IF→ID→EX, two registered stages:
  - It advances when !stall_i.
  - IF and ID stages clear when flush_i or mispredict_o is asserted. The EX resolution in that same cycle still applies.
- EX compare:
  - act = ex_valid_i && ex_is_branch_i && ex_taken_i.
  - mispredict_o = ex_valid_i && meta_ex.valid && (meta_ex.taken != act || (act && meta_ex.target != ex_target_i)).
  - redirect_pc_o = act ? ex_target_i : ex_pc_i+4.
- Training (RUN, ex_valid_i, !stall_i):
  - If ex_is_branch_i or meta_ex.taken: BHT saturating +1 when act, -1 otherwise. Clamp at 2'b11 and 2'b00.
  - A non-branch that was predicted taken (aliasing) is therefore unlearned.
  - When act: btb_we_o=1, addr=ex_pc_i[IDX_W+1:2], tag=ex_pc_i[31:IDX_W+2], pc=ex_target_i.
- Width rule: target bits [1:0] are not stored by the BTB; targets are assumed word-aligned.

Optional Feature:
- Macro BTB_PRED_STATS_EN.
- When defined, adds outputs stat_branches_o[31:0] and stat_mispred_o[31:0]:
  - stat_branches_o increments on each trained branch.
  - stat_mispred_o increments on each mispredict_o cycle.
  - Both saturate at 32'hFFFFFFFF, are reset to 0, and are held during INIT.
- When undefined, the ports and logic are absent.

Decomposition:
- Package bp_pkg holds:
  - IDX_W/TAG_W defaults.
  - cnt2_t (logic [1:0]).
  - The state enum {INIT, RUN}.
  - pred_meta_t struct {valid, taken, target[31:0]}.
- One sub-module, bht: 2**IDX_W x 2-bit table with async read, one write port, and the saturating-update logic.

Test Plan:
- Reset, then count cycles → ready_o rises exactly 1024 cycles after rst_n deasserts; pred_taken_o=0 throughout.
- Branch at 0x0000_1040 resolved taken to 0x0000_2000 twice → second resolution sets BHT 01→10→11. The next fetch of 0x1040 gives pred_taken_o=1, pred_pc_o=0x2000.
- Predicted taken 0x1040, resolved not-taken → mispredict_o=1, redirect_pc_o=0x1044, BHT 11→10, IF/ID metadata cleared.
- Alias: PC 0x0000_5040 (same index, different tag) after 0x1040 is trained → pred_taken_o=0, pred_pc_o=0x5044.
- stall_i held 3 cycles with ex_valid_i=1 → no BHT/BTB write, metadata unchanged. Release → training occurs once.
- rst_n pulsed low mid-RUN → ready_o=0 immediately, sweep restarts, previously trained 0x1040 predicts not-taken after re-init.
